// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with threshold flags, occupancy,
// sticky error flags and optional first-word-fall-through read mode.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   din, write        write data and write request
//   read              read request
//   clr_err           clears sticky overflow/underflow
//   dout, read_stb    read data and read-data-valid strobe
//   empty, full       count == 0 / count == DEPTH
//   almost_empty      count <= AEMPTY_TH
//   almost_full       count >= AFULL_TH
//   count             occupancy 0..DEPTH
//   overflow          sticky: a write was refused
//   underflow         sticky: a read was refused
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    input  logic             read,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             read_stb,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign empty        = r_count == '0;
    assign full         = r_count == CW'(DEPTH);
    assign almost_empty = r_count <= CW'(AEMPTY_TH);
    assign almost_full  = r_count >= CW'(AFULL_TH);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign w_rd_ok = read & ~empty;
    assign w_wr_ok = write & (~full | w_rd_ok);

    always_ff @(posedge clk)
        if (!rst && w_wr_ok)
            r_mem[r_wr_ptr] <= din;

    always_ff @(posedge clk)
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
            // A new error wins over a simultaneous clear.
            r_ovf <= (write & ~w_wr_ok) | (r_ovf & ~clr_err);
            r_udf <= (read & ~w_rd_ok) | (r_udf & ~clr_err);
        end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout     = r_mem[r_rd_ptr];
            assign read_stb = w_rd_ok;
        end else begin : g_reg
            logic [WIDTH-1:0] r_dout;
            logic             r_stb;
            always_ff @(posedge clk)
                if (rst) begin
                    r_dout <= '0;
                    r_stb  <= 1'b0;
                end else begin
                    r_stb <= w_rd_ok;
                    if (w_rd_ok)
                        r_dout <= r_mem[r_rd_ptr];
                end
            assign dout     = r_dout;
            assign read_stb = r_stb;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed table plus randomized checks of registered and FWFT FIFO instances.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] dout0, dout1;
    logic       stb0, stb1, e0, e1, f0, f1, ae0, ae1, af0, af1, ovf0, ovf1, udf0, udf1;
    logic [2:0] cnt0, cnt1;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_stb, m_ovf, m_udf;

    typedef struct {
        logic       w;
        logic       r;
        logic       c;
        logic [7:0] d;
        logic       stb;
        logic [7:0] dq;
        logic [2:0] cnt;
        logic       ovf;
        logic       udf;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .din(din), .write(write), .read(read), .clr_err(clr_err),
        .dout(dout0), .read_stb(stb0), .empty(e0), .full(f0), .almost_empty(ae0),
        .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .din(din), .write(write), .read(read), .clr_err(clr_err),
        .dout(dout1), .read_stb(stb1), .empty(e1), .full(f1), .almost_empty(ae1),
        .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d, input logic rs);
        logic rd, wr;
        @(negedge clk);
        write = w; read = r; clr_err = c; din = d; rst = rs;
        #1;
        if (!rs) begin
            chk("fwft_stb", stb1, r && q.size() != 0);
            if (q.size() != 0) chk("fwft_dout", dout1, q[0]);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_dout = '0; m_stb = 0; m_ovf = 0; m_udf = 0;
        end else begin
            rd = r && q.size() != 0;
            wr = w && (q.size() != 4 || rd);
            m_stb = rd;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(d);
            m_ovf = (w && !wr) || (m_ovf && !c);
            m_udf = (r && !rd) || (m_udf && !c);
        end
        chk("stb", stb0, m_stb);
        chk("dout", dout0, m_dout);
        chk("count", cnt0, q.size());
        chk("empty", e0, q.size() == 0);
        chk("full", f0, q.size() == 4);
        chk("almost_empty", ae0, q.size() <= 1);
        chk("almost_full", af0, q.size() >= 3);
        chk("overflow", ovf0, m_ovf);
        chk("underflow", udf0, m_udf);
        chk("fwft_count", cnt1, q.size());
        chk("fwft_empty", e1, q.size() == 0);
        chk("fwft_full", f1, q.size() == 4);
        chk("fwft_ae", ae1, q.size() <= 1);
        chk("fwft_af", af1, q.size() >= 3);
        chk("fwft_overflow", ovf1, m_ovf);
        chk("fwft_underflow", udf1, m_udf);
    endtask

    initial begin
        //                 w  r  c  din    stb dout   cnt ovf udf
        tv.push_back('{1, 0, 0, 8'h11, 0, 8'h00, 1, 0, 0});
        tv.push_back('{1, 0, 0, 8'h22, 0, 8'h00, 2, 0, 0});
        tv.push_back('{1, 0, 0, 8'h33, 0, 8'h00, 3, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'h11, 2, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'h22, 1, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'h33, 0, 0, 0});
        tv.push_back('{1, 0, 0, 8'hA0, 0, 8'h33, 1, 0, 0});
        tv.push_back('{1, 0, 0, 8'hA1, 0, 8'h33, 2, 0, 0});
        tv.push_back('{1, 0, 0, 8'hA2, 0, 8'h33, 3, 0, 0});
        tv.push_back('{1, 0, 0, 8'hA3, 0, 8'h33, 4, 0, 0});
        tv.push_back('{1, 0, 0, 8'hFF, 0, 8'h33, 4, 1, 0});
        tv.push_back('{0, 0, 1, 8'h00, 0, 8'h33, 4, 0, 0});
        tv.push_back('{1, 1, 0, 8'hB4, 1, 8'hA0, 4, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'hA1, 3, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'hA2, 2, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'hA3, 1, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'hB4, 0, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 0, 8'hB4, 0, 0, 1});
        tv.push_back('{1, 1, 0, 8'h5C, 0, 8'hB4, 1, 0, 1});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'h5C, 0, 0, 1});
        tv.push_back('{0, 0, 1, 8'h00, 0, 8'h5C, 0, 0, 0});
        tv.push_back('{0, 1, 1, 8'h00, 0, 8'h5C, 0, 0, 1});
        tv.push_back('{0, 0, 1, 8'h00, 0, 8'h5C, 0, 0, 0});
        tv.push_back('{1, 0, 0, 8'h7E, 0, 8'h5C, 1, 0, 0});
        tv.push_back('{0, 1, 0, 8'h00, 1, 8'h7E, 0, 0, 0});
        tv.push_back('{1, 0, 0, 8'h01, 0, 8'h7E, 1, 0, 0});
        tv.push_back('{1, 0, 0, 8'h02, 0, 8'h7E, 2, 0, 0});

        step(0, 0, 0, 8'h00, 1);
        chk("rst_empty", e0, 1);
        chk("rst_almost_empty", ae0, 1);
        chk("rst_full", f0, 0);
        chk("rst_almost_full", af0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_dout", dout0, 0);

        foreach (tv[i]) begin
            step(tv[i].w, tv[i].r, tv[i].c, tv[i].d, 0);
            chk($sformatf("tv%0d_stb", i), stb0, tv[i].stb);
            chk($sformatf("tv%0d_dout", i), dout0, tv[i].dq);
            chk($sformatf("tv%0d_count", i), cnt0, tv[i].cnt);
            chk($sformatf("tv%0d_ovf", i), ovf0, tv[i].ovf);
            chk($sformatf("tv%0d_udf", i), udf0, tv[i].udf);
        end

        step(0, 0, 0, 8'h00, 1);
        chk("midrst_count", cnt0, 0);
        chk("midrst_empty", e0, 1);
        chk("midrst_fwft_count", cnt1, 0);
        chk("midrst_fwft_empty", e1, 1);

        // FWFT: word visible the cycle after its write, acknowledged in the read cycle.
        step(1, 0, 0, 8'h7E, 0);
        #2;
        chk("fwft_pre_dout", dout1, 8'h7E);
        chk("fwft_pre_empty", e1, 0);
        step(0, 1, 0, 8'h00, 0);
        chk("fwft_post_empty", e1, 1);

        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = ((i / 60) % 2) ? 75 : 30;
            step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (105 - wb),
                 $urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
